// File: rtl/ecc_pkg.sv
// Shared op/width/state types and codeword layout helpers for the extended-Hamming engine.
// Pure declarations and functions; no state, no latency, no flow control.
package ecc_pkg;

    typedef enum logic [1:0] {
        OP_ENC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_FULL = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        W_CW8  = 2'd0,
        W_CW16 = 2'd1,
        W_CW32 = 2'd2
    } width_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENC   = 3'd1,
        ST_NOISE = 3'd2,
        ST_DEC   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int CW_LEN_8    = 8;
    localparam int CW_LEN_16   = 16;
    localparam int CW_LEN_32   = 32;
    localparam int DATA_LEN_8  = 4;
    localparam int DATA_LEN_16 = 11;
    localparam int DATA_LEN_32 = 26;

    // Code 3 is not a distinct size; it folds onto the 32-bit codeword.
    function automatic width_e width_decode(input logic [1:0] code);
        case (code)
            2'd0:    return W_CW8;
            2'd1:    return W_CW16;
            default: return W_CW32;
        endcase
    endfunction

    function automatic int cw_len(input width_e w);
        case (w)
            W_CW8:   return CW_LEN_8;
            W_CW16:  return CW_LEN_16;
            default: return CW_LEN_32;
        endcase
    endfunction

    function automatic logic [31:0] cw_mask(input width_e w);
        case (w)
            W_CW8:   return (32'd1 << CW_LEN_8) - 32'd1;
            W_CW16:  return (32'd1 << CW_LEN_16) - 32'd1;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] data_mask(input width_e w);
        case (w)
            W_CW8:   return (32'd1 << DATA_LEN_8) - 32'd1;
            W_CW16:  return (32'd1 << DATA_LEN_16) - 32'd1;
            default: return (32'd1 << DATA_LEN_32) - 32'd1;
        endcase
    endfunction

    // Data bits occupy the non-power-of-two positions in ascending order.
    function automatic logic [31:0] scatter(input logic [31:0] data, input width_e w);
        logic [31:0] cw;
        int          k;
        cw = '0;
        k  = 0;
        for (int j = 1; j < 32; j++) begin
            if (j < cw_len(w) && (j & (j - 1)) != 0) begin
                cw[5'(j)] = data[5'(k)];
                k++;
            end
        end
        return cw;
    endfunction

    function automatic logic [31:0] gather(input logic [31:0] cw, input width_e w);
        logic [31:0] data;
        int          k;
        data = '0;
        k    = 0;
        for (int j = 1; j < 32; j++) begin
            if (j < cw_len(w) && (j & (j - 1)) != 0) begin
                data[5'(k)] = cw[5'(j)];
                k++;
            end
        end
        return data;
    endfunction

endpackage

// File: rtl/ecc_hamming_calc.sv
// Syndrome (XOR of indices of set bits 1..N-1) and overall parity (bits N-1..0) of a codeword.
// Purely combinational; bits at or above the selected codeword length are ignored.
module ecc_hamming_calc
    import ecc_pkg::*;
(
    input  logic [31:0] word_i,
    input  width_e      width_i,
    output logic [4:0]  syndrome_o,
    output logic        parity_o
);

    logic [31:0] masked;

    always_comb begin
        masked     = word_i & cw_mask(width_i);
        syndrome_o = '0;
        for (int j = 1; j < 32; j++) begin
            if (masked[5'(j)]) begin
                syndrome_o = syndrome_o ^ 5'(j);
            end
        end
        parity_o = ^masked;
    end

endmodule

// File: rtl/ecc_engine.sv
// Extended-Hamming encode/decode/full-channel FSM; done one cycle after E+1 (enc/dec) or E+3 (full).
// Starts are dropped while busy or for reserved ops; ECC_ENGINE_OUT_REG_EN adds one output stage (+1 latency).
module ecc_engine
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy
);

    state_e      state_q;
    op_e         op_q;
    width_e      width_q;
    logic [31:0] work_q;
    logic [31:0] noise_q;
    logic [31:0] res_data_q;
    logic [1:0]  res_err_q;
    logic        done_q;
    logic        busy_q;

    op_e         req_op;
    width_e      req_width;
    logic        hold_off;
    logic        accept;

    logic [31:0] calc_word;
    logic [4:0]  syn;
    logic        par;
    logic [31:0] enc_cw;
    logic [31:0] dec_cw;
    logic [31:0] dec_data;
    logic [1:0]  dec_err;

    logic        unused_bits;
    assign unused_bits = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    assign req_op    = op_e'(CTRL[1:0]);
    assign req_width = width_decode(CODEWORD_WIDTH[1:0]);
    assign accept    = start && (state_q == ST_IDLE) && (req_op != OP_RSVD) && !hold_off;

    // One calculator serves both directions: data is scattered into place before encoding.
    assign calc_word = (state_q == ST_ENC) ? scatter(work_q, width_q) : work_q;

    ecc_hamming_calc u_calc (
        .word_i     (calc_word),
        .width_i    (width_q),
        .syndrome_o (syn),
        .parity_o   (par)
    );

    always_comb begin
        enc_cw     = calc_word;
        enc_cw[1]  = syn[0];
        enc_cw[2]  = syn[1];
        enc_cw[4]  = syn[2];
        enc_cw[8]  = syn[3];
        enc_cw[16] = syn[4];
        // Each inserted parity bit toggles overall parity once, hence par ^ ^syn.
        enc_cw[0]  = par ^ (^syn);
    end

    always_comb begin
        dec_cw  = work_q;
        dec_err = 2'd0;
        if (par) begin
            dec_err = 2'd1;
            dec_cw  = work_q ^ (32'd1 << syn);
        end else if (syn != 5'd0) begin
            dec_err = 2'd2;
        end
        dec_data = gather(dec_cw, width_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ENC;
            width_q    <= W_CW8;
            work_q     <= '0;
            noise_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= req_op;
                        width_q    <= req_width;
                        noise_q    <= NOISE[31:0] & cw_mask(req_width);
                        work_q     <= DATA_IN[31:0] & ((req_op == OP_DEC) ? cw_mask(req_width)
                                                                          : data_mask(req_width));
                        res_data_q <= '0;
                        res_err_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= (req_op == OP_DEC) ? ST_DEC : ST_ENC;
                    end
                end
                ST_ENC: begin
                    work_q <= enc_cw;
                    if (op_q == OP_FULL) begin
                        state_q <= ST_NOISE;
                    end else begin
                        res_data_q <= enc_cw;
                        res_err_q  <= 2'd0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_NOISE: begin
                    work_q  <= work_q ^ noise_q;
                    state_q <= ST_DEC;
                end
                ST_DEC: begin
                    res_data_q <= dec_data;
                    res_err_q  <= dec_err;
                    done_q     <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ECC_ENGINE_OUT_REG_EN
    logic [31:0] out_data_q;
    logic [1:0]  out_err_q;
    logic        out_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q <= '0;
            out_err_q  <= '0;
            out_done_q <= 1'b0;
        end else begin
            out_data_q <= res_data_q;
            out_err_q  <= res_err_q;
            out_done_q <= done_q;
        end
    end

    // The FSM is already back in IDLE while the delayed strobe is out; keep it closed to starts.
    assign hold_off       = out_done_q;
    assign data_out       = AMBA_WORD'(out_data_q);
    assign num_of_errors  = out_err_q;
    assign operation_done = out_done_q;
    assign busy           = busy_q | out_done_q;
`else
    assign hold_off       = 1'b0;
    assign data_out       = AMBA_WORD'(res_data_q);
    assign num_of_errors  = res_err_q;
    assign operation_done = done_q;
    assign busy           = busy_q;
`endif

endmodule

// File: tb/tb_ecc_engine.sv
// Directed bench for ecc_engine: hand-computed vectors, control corner cases, and model-checked random round trips.
module tb_ecc_engine;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] CTRL = '0;
    logic [AW-1:0] DATA_IN = '0;
    logic [AW-1:0] CODEWORD_WIDTH = '0;
    logic [AW-1:0] NOISE = '0;
    logic [AW-1:0] data_out;
    logic [1:0]    num_of_errors;
    logic          operation_done;
    logic          busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [1:0]  r_w;
    logic [31:0] r_d, r_nz, r_cw, r_ed;
    logic [1:0]  r_ee;
    int          r_n, r_b1, r_b2;
    logic        seen_done, seen_busy;

    always #5 clk = ~clk;

    ecc_engine #(.AMBA_WORD(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .CTRL           (CTRL),
        .DATA_IN        (DATA_IN),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .NOISE          (NOISE),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .operation_done (operation_done),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int cw_n(input logic [1:0] w);
        return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] n_mask(input int n);
        return (n < 32) ? ((32'd1 << n) - 32'd1) : 32'hFFFF_FFFF;
    endfunction

    // Reference encoder: each parity computed straight from its coverage definition.
    function automatic logic [31:0] m_enc(input logic [31:0] d, input logic [1:0] w);
        logic [31:0] cw;
        logic        b;
        int          n, k;
        cw = '0;
        n  = cw_n(w);
        k  = 0;
        for (int j = 1; j < n; j++) begin
            if ((j & (j - 1)) != 0) begin
                cw[j] = d[k];
                k++;
            end
        end
        for (int p = 1; p < n; p = p * 2) begin
            b = 1'b0;
            for (int j = 1; j < n; j++) if (j != p && (j & p) != 0) b = b ^ cw[j];
            cw[p] = b;
        end
        for (int j = 1; j < n; j++) cw[0] = cw[0] ^ cw[j];
        return cw;
    endfunction

    function automatic void m_dec(input logic [31:0] cw_in, input logic [1:0] w,
                                  output logic [31:0] d, output logic [1:0] e);
        logic [31:0] cw;
        logic        c, p;
        int          n, s, k;
        cw = cw_in;
        n  = cw_n(w);
        s  = 0;
        p  = 1'b0;
        for (int b = 1; b < n; b = b * 2) begin
            c = 1'b0;
            for (int j = 1; j < n; j++) if ((j & b) != 0) c = c ^ cw[j];
            if (c) s = s + b;
        end
        for (int j = 0; j < n; j++) p = p ^ cw[j];
        if (p) begin
            e     = 2'd1;
            cw[s] = ~cw[s];
        end else if (s != 0) begin
            e = 2'd2;
        end else begin
            e = 2'd0;
        end
        d = '0;
        k = 0;
        for (int j = 1; j < n; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[k] = cw[j];
                k++;
            end
        end
    endfunction

    // poke: 0 none, 1 extra start while busy, 2 extra start in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] din,
                          input logic [1:0] w, input logic [31:0] nz, input int lat,
                          input logic [31:0] exp_d, input logic [1:0] exp_e, input int poke);
        int   cyc;
        logic got;
        @(negedge clk);
        CTRL           = 32'(op);
        DATA_IN        = din;
        CODEWORD_WIDTH = 32'(w);
        NOISE          = nz;
        start          = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        chk({tag, ":clear"}, data_out, 32'd0);
        if (poke == 1) begin
            CTRL    = 32'd1;
            DATA_IN = 32'h55;
            start   = 1'b1;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 16) begin
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
            @(negedge clk);
            got = operation_done;
        end
        chk({tag, ":latency"}, 32'(cyc), 32'(lat));
        chk({tag, ":data"}, data_out, exp_d);
        chk({tag, ":errors"}, 32'(num_of_errors), 32'(exp_e));
        if (poke == 2) begin
            CTRL           = 32'd0;
            DATA_IN        = 32'h3;
            CODEWORD_WIDTH = 32'd0;
            start          = 1'b1;
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({tag, ":done_after"}, 32'(operation_done), 32'd0);
        chk({tag, ":busy_after"}, 32'(busy), 32'd0);
        chk({tag, ":hold"}, data_out, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset:data", data_out, 32'd0);
        chk("reset:errors", 32'(num_of_errors), 32'd0);
        chk("reset:done", 32'(operation_done), 32'd0);
        chk("reset:busy", 32'(busy), 32'd0);
        rst = 1'b1;

        run_op("enc8", 2'd0, 32'h0000_000B, 2'd0, 32'h0, 1, 32'h0000_00AA, 2'd0, 0);
        run_op("dec8", 2'd1, 32'h0000_00AA, 2'd0, 32'h0, 1, 32'h0000_000B, 2'd0, 0);
        run_op("full8_n08", 2'd2, 32'h0000_000B, 2'd0, 32'h08, 3, 32'h0000_000B, 2'd1, 0);
        run_op("full8_n01", 2'd2, 32'h0000_000B, 2'd0, 32'h01, 3, 32'h0000_000B, 2'd1, 0);
        run_op("full8_dbl", 2'd2, 32'h0000_000B, 2'd0, 32'h0C, 3, 32'h0000_000A, 2'd2, 1);
        run_op("dec8_dbl", 2'd1, 32'h0000_00A6, 2'd0, 32'h0, 1, 32'h0000_000A, 2'd2, 2);
        run_op("enc8_mask", 2'd0, 32'hFFFF_FFFB, 2'd0, 32'h0, 1, 32'h0000_00AA, 2'd0, 0);
        run_op("enc16", 2'd0, 32'h0000_0001, 2'd1, 32'h0, 1, 32'h0000_000F, 2'd0, 0);
        run_op("enc32", 2'd0, 32'h03FF_FFFF, 2'd2, 32'h0, 1, 32'hFFFF_FFFF, 2'd0, 0);
        run_op("full32_w3", 2'd2, 32'h03FF_FFFF, 2'd3, 32'h0001_0000, 3, 32'h03FF_FFFF, 2'd1, 0);
        run_op("dec32", 2'd1, 32'hFFFF_FFFF, 2'd2, 32'h0, 1, 32'h03FF_FFFF, 2'd0, 0);

        // Reserved op: nothing starts, previous results stay.
        @(negedge clk);
        CTRL    = 32'd3;
        DATA_IN = 32'h0000_000B;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen_done = seen_done | operation_done;
            seen_busy = seen_busy | busy;
        end
        chk("rsvd:done", 32'(seen_done), 32'd0);
        chk("rsvd:busy", 32'(seen_busy), 32'd0);
        chk("rsvd:hold", data_out, 32'h03FF_FFFF);

        // Reset while in the NOISE state aborts silently.
        @(negedge clk);
        CTRL           = 32'd2;
        DATA_IN        = 32'h0000_000B;
        CODEWORD_WIDTH = 32'd0;
        NOISE          = 32'h08;
        start          = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid:busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid:data", data_out, 32'd0);
        chk("rstmid:errors", 32'(num_of_errors), 32'd0);
        chk("rstmid:busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen_done = seen_done | operation_done;
        end
        chk("rstmid:no_done", 32'(seen_done), 32'd0);

        run_op("after_rst", 2'd0, 32'h0000_000B, 2'd0, 32'h0, 1, 32'h0000_00AA, 2'd0, 0);

        for (int i = 0; i < 10; i++) begin
            r_w  = 2'($urandom_range(0, 3));
            r_n  = cw_n(r_w);
            r_d  = $urandom;
            r_b1 = $urandom_range(0, r_n - 1);
            r_b2 = (r_b1 + 1 + $urandom_range(0, r_n - 2)) % r_n;
            r_nz = (r_n < 32) ? ($urandom << r_n) : 32'h0;
            if (i % 3 >= 1) r_nz[r_b1] = 1'b1;
            if (i % 3 == 2) r_nz[r_b2] = 1'b1;
            r_cw = m_enc(r_d, r_w);
            run_op($sformatf("rnd_enc%0d", i), 2'd0, r_d, r_w, 32'h0, 1, r_cw, 2'd0, 0);
            m_dec(r_cw ^ (r_nz & n_mask(r_n)), r_w, r_ed, r_ee);
            run_op($sformatf("rnd_full%0d", i), 2'd2, r_d, r_w, r_nz, 3, r_ed, r_ee, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
